// File: rtl/gps_multi_correlator_if.sv
// Wishbone slave bus bundle for the GPS multi-channel correlator.
// Ports: wb_adr_i/wb_dat_i/wb_sel_i/wb_cyc_i/wb_stb_i/wb_we_i in, wb_dat_o/wb_ack_o out.
interface gps_multi_correlator_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
      input  wb_dat_o, wb_ack_o
   );
   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/gps_multi_correlator.sv
// GPS multi-channel correlator: time base, NUM_CH tracking channels, Wishbone register map.
// Ports: correlator_clk, correlator_rst (async, high), sign/mag samples, accum_int irq, wb slave.
// Optional: GPS_CORR_IRQ_MASK_EN adds irq_mask at word 0xE5 gating accum_int.
module time_base (
   input  logic        clk,
   input  logic        rstn,
   input  logic [23:0] prog_tic,
   input  logic [23:0] prog_accum_int,
   output logic        tic_enable,
   output logic        accum_enable,
   output logic [23:0] tic_count,
   output logic [23:0] accum_count
);
   // >= so a shrunk period takes effect at once instead of waiting for wrap
   assign tic_enable   = (tic_count >= prog_tic);
   assign accum_enable = (accum_count >= prog_accum_int);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tic_count   <= '0;
         accum_count <= '0;
      end else begin
         tic_count   <= tic_enable ? 24'd0 : tic_count + 24'd1;
         accum_count <= accum_enable ? 24'd0 : accum_count + 24'd1;
      end
   end
endmodule

module tracking_channel (
   input  logic             clk,
   input  logic             rstn,
   input  logic             sign,
   input  logic             mag,
   input  logic             accum_enable,
   input  logic [9:0]       prn_key,
   input  logic [28:0]      carr_nco,
   input  logic [27:0]      code_nco,
   input  logic [10:0]      code_slew,
   input  logic [10:0]      epoch_load,
   input  logic             prn_key_enable,
   input  logic             slew_enable,
   input  logic             epoch_enable,
   output logic             dump,
   output logic [5:0][15:0] iq,
   output logic [31:0]      carrier_val,
   output logic [20:0]      code_val,
   output logic [10:0]      epoch,
   output logic [10:0]      epoch_check
);
   logic [27:0]      code_ph;
   logic [28:0]      code_sum;
   logic [9:0]       g2;
   logic [10:0]      slew_cnt;
   logic [5:0][15:0] acc;
   logic [5:0][15:0] acc_nxt;
   logic [15:0]      mv;
   logic             i_bit;
   logic             q_bit;

   function automatic logic [15:0] step(input logic [15:0] a,
                                        input logic neg,
                                        input logic [15:0] v);
      return neg ? a - v : a + v;
   endfunction

   // code NCO rollover marks the end of an integration period
   assign code_sum = {1'b0, code_ph} + {1'b0, code_nco};
   assign dump     = code_sum[28] & (slew_cnt == 11'd0);
   assign code_val = code_ph[27:7];
   assign mv       = {14'd0, mag, 1'b1};
   assign i_bit    = carrier_val[31];
   assign q_bit    = carrier_val[31] ^ carrier_val[30];

   // even index = I, odd = Q; pairs are early/prompt/late code taps
   assign acc_nxt[0] = step(acc[0], sign ^ i_bit ^ g2[9], mv);
   assign acc_nxt[1] = step(acc[1], sign ^ q_bit ^ g2[9], mv);
   assign acc_nxt[2] = step(acc[2], sign ^ i_bit ^ g2[8], mv);
   assign acc_nxt[3] = step(acc[3], sign ^ q_bit ^ g2[8], mv);
   assign acc_nxt[4] = step(acc[4], sign ^ i_bit ^ g2[7], mv);
   assign acc_nxt[5] = step(acc[5], sign ^ q_bit ^ g2[7], mv);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         carrier_val <= '0;
         code_ph     <= '0;
         g2          <= '0;
         slew_cnt    <= '0;
         epoch       <= '0;
         epoch_check <= '0;
         acc         <= '0;
         iq          <= '0;
      end else begin
         carrier_val <= carrier_val + {3'd0, carr_nco};
         // slewing freezes code phase for code_slew cycles
         if (slew_enable)
            slew_cnt <= code_slew;
         else if (slew_cnt != 11'd0)
            slew_cnt <= slew_cnt - 11'd1;
         else
            code_ph <= code_sum[27:0];
         if (prn_key_enable)
            g2 <= prn_key;
         else if (dump)
            g2 <= {g2[8:0], g2[9] ^ g2[8] ^ g2[7] ^ g2[5] ^ g2[2] ^ g2[1]};
         if (epoch_enable)
            epoch <= epoch_load;
         else if (dump)
            epoch <= epoch + 11'd1;
         if (accum_enable)
            epoch_check <= epoch;
         if (dump) begin
            iq  <= acc_nxt;
            acc <= '0;
         end else begin
            acc <= acc_nxt;
         end
      end
   end
endmodule

module gps_multi_correlator #(
   parameter int NUM_CH = 4
) (
   input  logic                 correlator_clk,
   input  logic                 correlator_rst,
   input  logic                 sign,
   input  logic                 mag,
   output logic                 accum_int,
   gps_multi_correlator_if.slave wb
);
   typedef enum logic [1:0] {IDLE, DELAYACK1, DELAYACK2, ACK} state_t;

   state_t            state;
   logic              sw_rst;
   logic              rstn;
   logic [7:0]        w;
   logic [3:0]        ch;
   logic [3:0]        off;
   logic              wr;
   logic [31:0]       rd;
   logic [31:0]       rd_or [NUM_CH+1];
   logic [23:0]       prog_tic;
   logic [23:0]       prog_accum_int;
   logic [23:0]       tic_count;
   logic [23:0]       accum_count;
   logic [31:0]       scratch;
   logic              tic_enable;
   logic              accum_enable;
   logic              status_clr;
   logic              nd_clr;
   logic [1:0]        status;
   logic [1:0]        status_nxt;
   logic [NUM_CH-1:0] new_data;
   logic [NUM_CH-1:0] dump;
   logic              unused;

   assign w          = wb.wb_adr_i[9:2];
   assign ch         = w[7:4];
   assign off        = w[3:0];
   assign wr         = (state == IDLE) & wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i;
   assign rstn       = ~correlator_rst & ~sw_rst;
   assign status_clr = wr & (w == 8'hE4) & wb.wb_dat_i[0];
   assign nd_clr     = wr & (w == 8'hE4) & wb.wb_dat_i[1];
   assign unused     = ^{wb.wb_sel_i, wb.wb_adr_i[31:10], wb.wb_adr_i[1:0]};
   assign rd_or[0]   = '0;

   time_base u_tb (
      .clk(correlator_clk), .rstn, .prog_tic, .prog_accum_int,
      .tic_enable, .accum_enable, .tic_count, .accum_count
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             sel;
      logic [2:0]       en;
      logic [9:0]       prn_key;
      logic [28:0]      carr_nco;
      logic [27:0]      code_nco;
      logic [10:0]      code_slew;
      logic [10:0]      epoch_load;
      logic [5:0][15:0] iq;
      logic [31:0]      carrier_val;
      logic [20:0]      code_val;
      logic [10:0]      epoch;
      logic [10:0]      epoch_check;
      logic [31:0]      mux;

      assign sel = (w < 8'hC0) && (ch == 4'(c));
      assign en  = (wr && sel && off == 4'hF) ? wb.wb_dat_i[2:0] : 3'b000;

      always_ff @(posedge correlator_clk or posedge correlator_rst) begin
         if (correlator_rst) begin
            prn_key    <= '0;
            carr_nco   <= '0;
            code_nco   <= '0;
            code_slew  <= '0;
            epoch_load <= '0;
         end else if (wr && sel) begin
            case (off)
               4'h0:    prn_key    <= wb.wb_dat_i[9:0];
               4'h1:    carr_nco   <= wb.wb_dat_i[28:0];
               4'h2:    code_nco   <= wb.wb_dat_i[27:0];
               4'h3:    code_slew  <= wb.wb_dat_i[10:0];
               4'hE:    epoch_load <= wb.wb_dat_i[10:0];
               default: ;
            endcase
         end
      end

      always_comb begin
         case (off)
            4'h4:    mux = {16'd0, iq[0]};
            4'h5:    mux = {16'd0, iq[1]};
            4'h6:    mux = {16'd0, iq[2]};
            4'h7:    mux = {16'd0, iq[3]};
            4'h8:    mux = {16'd0, iq[4]};
            4'h9:    mux = {16'd0, iq[5]};
            4'hA:    mux = carrier_val;
            4'hB:    mux = {11'd0, code_val};
            4'hC:    mux = {21'd0, epoch};
            4'hD:    mux = {21'd0, epoch_check};
            default: mux = '0;
         endcase
      end

      assign rd_or[c+1] = rd_or[c] | (sel ? mux : 32'd0);

      tracking_channel u_ch (
         .clk(correlator_clk), .rstn, .sign, .mag, .accum_enable,
         .prn_key, .carr_nco, .code_nco, .code_slew, .epoch_load,
         .prn_key_enable(en[0]), .slew_enable(en[1]), .epoch_enable(en[2]),
         .dump(dump[c]), .iq, .carrier_val, .code_val, .epoch, .epoch_check
      );
   end

`ifdef GPS_CORR_IRQ_MASK_EN
   logic [1:0] irq_mask;

   always_ff @(posedge correlator_clk or posedge correlator_rst) begin
      if (correlator_rst)
         irq_mask <= 2'b10;
      else if (wr && w == 8'hE5)
         irq_mask <= wb.wb_dat_i[1:0];
   end
`endif

   always_ff @(posedge correlator_clk or posedge correlator_rst) begin
      if (correlator_rst) begin
         sw_rst         <= 1'b0;
         prog_tic       <= '0;
         prog_accum_int <= '0;
         scratch        <= '0;
      end else if (wr) begin
         case (w)
            8'hF0:   sw_rst         <= wb.wb_dat_i[0];
            8'hF1:   prog_tic       <= wb.wb_dat_i[23:0];
            8'hF2:   prog_accum_int <= wb.wb_dat_i[23:0];
            8'hF3:   scratch        <= wb.wb_dat_i;
            default: ;
         endcase
      end
   end

   // a set in the same cycle as a clear wins
   assign status_nxt = (status & ~{2{status_clr}}) | {accum_enable, tic_enable};

   always_ff @(posedge correlator_clk or negedge rstn) begin
      if (!rstn) begin
         status    <= '0;
         new_data  <= '0;
         accum_int <= 1'b0;
      end else begin
         status   <= status_nxt;
         new_data <= (nd_clr ? '0 : new_data) | dump;
`ifdef GPS_CORR_IRQ_MASK_EN
         accum_int <= |(status_nxt & irq_mask);
`else
         accum_int <= accum_enable | (accum_int & ~status_clr);
`endif
      end
   end

   always_comb begin
      case (w)
         8'hE0:   rd = {30'd0, status};
         8'hE1:   rd = 32'(new_data);
         8'hE2:   rd = {8'd0, tic_count};
         8'hE3:   rd = {8'd0, accum_count};
`ifdef GPS_CORR_IRQ_MASK_EN
         8'hE5:   rd = {30'd0, irq_mask};
`endif
         8'hEF:   rd = 32'h6E6D7275;
         8'hF3:   rd = scratch;
         default: rd = rd_or[NUM_CH];
      endcase
   end

   always_ff @(posedge correlator_clk or posedge correlator_rst) begin
      if (correlator_rst) begin
         state       <= IDLE;
         wb.wb_ack_o <= 1'b0;
         wb.wb_dat_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wb.wb_cyc_i && wb.wb_stb_i) begin
                  state       <= wb.wb_we_i ? ACK : DELAYACK1;
                  wb.wb_ack_o <= wb.wb_we_i;
               end
            end
            DELAYACK1: state <= DELAYACK2;
            DELAYACK2: begin
               state       <= ACK;
               wb.wb_ack_o <= 1'b1;
               wb.wb_dat_o <= rd;
            end
            default: begin
               state       <= IDLE;
               wb.wb_ack_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gps_multi_correlator.sv
// Randomized bench for gps_multi_correlator with a register-map reference model.
// Drives the Wishbone interface, checks latency, read data, status/new_data rules and reset.
module tb_gps_multi_correlator;
   localparam int NCH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sign = 1'b0;
   logic        mag = 1'b0;
   logic        accum_int;
   logic [31:0] q;
   int          total = 0;
   int          bad = 0;

   logic [31:0] m_prn  [NCH];
   logic [31:0] m_carr [NCH];
   logic [31:0] m_code [NCH];
   logic [31:0] m_slew [NCH];
   logic [31:0] m_eld  [NCH];
   logic [31:0] m_tic, m_acc, m_scr, m_mask;

   gps_multi_correlator_if bus ();

   gps_multi_correlator #(.NUM_CH(NCH)) dut (
      .correlator_clk(clk),
      .correlator_rst(rst),
      .sign(sign),
      .mag(mag),
      .accum_int(accum_int),
      .wb(bus)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         sign = 1'($urandom);
         mag  = 1'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic we, input logic [7:0] w, input logic [31:0] d,
                       output logic [31:0] rq, output int lat);
      @(negedge clk);
      bus.wb_adr_i = {22'd0, w, 2'b00};
      bus.wb_dat_i = d;
      bus.wb_we_i  = we;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.wb_ack_o && lat < 8);
      rq = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wb_wr(input logic [7:0] w, input logic [31:0] d);
      logic [31:0] rq;
      int lat;
      xfer(1'b1, w, d, rq, lat);
      chk("wr_lat", lat, 1);
   endtask

   task automatic wb_rd(input logic [7:0] w, output logic [31:0] rq);
      int lat;
      xfer(1'b0, w, 32'd0, rq, lat);
      chk("rd_lat", lat, 3);
   endtask

   // register-map model of the write-side state
   task automatic m_wr(input logic [7:0] w, input logic [31:0] d);
      int c;
      c = int'(w[7:4]);
      if (w < 8'hC0) begin
         if (c < NCH) begin
            case (w[3:0])
               4'h0: m_prn[c]  = d & 32'h3FF;
               4'h1: m_carr[c] = d & 32'h1FFF_FFFF;
               4'h2: m_code[c] = d & 32'h0FFF_FFFF;
               4'h3: m_slew[c] = d & 32'h7FF;
               4'hE: m_eld[c]  = d & 32'h7FF;
               default: ;
            endcase
         end
      end else begin
         case (w)
            8'hF1: m_tic = d & 32'hFF_FFFF;
            8'hF2: m_acc = d & 32'hFF_FFFF;
            8'hF3: m_scr = d;
            8'hE5: m_mask = d & 32'h3;
            default: ;
         endcase
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_prn0"},  dut.g_ch[0].prn_key,    m_prn[0]);
      chk({tag, "_prn1"},  dut.g_ch[1].prn_key,    m_prn[1]);
      chk({tag, "_carr0"}, dut.g_ch[0].carr_nco,   m_carr[0]);
      chk({tag, "_carr1"}, dut.g_ch[1].carr_nco,   m_carr[1]);
      chk({tag, "_code0"}, dut.g_ch[0].code_nco,   m_code[0]);
      chk({tag, "_code1"}, dut.g_ch[1].code_nco,   m_code[1]);
      chk({tag, "_slew0"}, dut.g_ch[0].code_slew,  m_slew[0]);
      chk({tag, "_slew1"}, dut.g_ch[1].code_slew,  m_slew[1]);
      chk({tag, "_eld0"},  dut.g_ch[0].epoch_load, m_eld[0]);
      chk({tag, "_eld1"},  dut.g_ch[1].epoch_load, m_eld[1]);
      chk({tag, "_tic"},   dut.prog_tic,           m_tic);
      chk({tag, "_acc"},   dut.prog_accum_int,     m_acc);
   endtask

   initial begin
      logic [7:0]  w;
      logic [31:0] d;
      logic [31:0] exp_mask;
      int          acks;
      logic [3:0]  offs [5];

      offs[0] = 4'h0; offs[1] = 4'h1; offs[2] = 4'h2; offs[3] = 4'h3; offs[4] = 4'hE;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = 4'hF;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         m_prn[i] = 0; m_carr[i] = 0; m_code[i] = 0; m_slew[i] = 0; m_eld[i] = 0;
      end
      m_tic = 0; m_acc = 0; m_scr = 0; m_mask = 32'h2;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", bus.wb_ack_o, 0);
      chk("rst_dat", bus.wb_dat_o, 0);
      chk("rst_irq", accum_int, 0);
      rst = 1'b0;

      // periods of zero fire both enables every cycle: set beats clear
      wb_wr(8'hE4, 32'h1);
      chk("set_wins_irq", accum_int, 1);
      wb_rd(8'hE0, q);
      chk("set_wins_status", q, 32'h3);
      wb_rd(8'hE3, q);
      chk("accum_cnt_zero", q, 0);

      // long periods, then a clear really clears
      wb_wr(8'hF1, 32'hFF_FFFF); m_wr(8'hF1, 32'hFF_FFFF);
      wb_wr(8'hF2, 32'hFF_FFFF); m_wr(8'hF2, 32'hFF_FFFF);
      wb_wr(8'hE4, 32'h1);
`ifdef GPS_CORR_IRQ_MASK_EN
      chk("clr_irq", accum_int, 0);
`else
      chk("clr_irq", accum_int, 0);
`endif
      wb_rd(8'hE0, q);
      chk("clr_status", q, 0);

      // channel write lands in ch1 only, ack lasts one cycle
      wb_wr(8'h11, 32'h1234567); m_wr(8'h11, 32'h1234567);
      @(negedge clk);
      chk("ack_one_cycle", bus.wb_ack_o, 0);
      chk("ch1_carr", dut.g_ch[1].carr_nco, 32'h1234567);
      chk("ch0_carr", dut.g_ch[0].carr_nco, 0);

      wb_rd(8'hEF, q);
      chk("ident", q, 32'h6E6D7275);

      // channel beyond NUM_CH
      wb_wr(8'h31, 32'hFFFF_FFFF);
      wb_rd(8'h31, q);
      chk("bad_ch_rd", q, 0);
      cmp_model("bad_ch");

      // new_data clear spares a channel dumping in the same cycle
      wb_wr(8'h02, 32'hFFF_FFFF); m_wr(8'h02, 32'hFFF_FFFF);
      wb_wr(8'h12, 32'hFFF_FFFF); m_wr(8'h12, 32'hFFF_FFFF);
      repeat (4) @(negedge clk);
      wb_wr(8'h12, 32'h0); m_wr(8'h12, 32'h0);
      wb_rd(8'hE1, q);
      chk("nd_both", q, 32'h3);
      wb_wr(8'hE4, 32'h2);
      wb_rd(8'hE1, q);
      chk("nd_clr_dump", q, 32'h1);

      // software reset holds the datapath, bus registers survive
      wb_wr(8'hF0, 32'h1);
      wb_rd(8'hE1, q);
      chk("swrst_nd", q, 0);
      wb_rd(8'hE2, q);
      chk("swrst_tic", q, 0);
      wb_wr(8'hF3, 32'hA5A5_5A5A); m_wr(8'hF3, 32'hA5A5_5A5A);
      wb_rd(8'hF3, q);
      chk("swrst_scr", q, m_scr);
      chk("swrst_carr", dut.g_ch[1].carr_nco, m_carr[1]);
      wb_wr(8'hF0, 32'h0);
      wb_rd(8'hE1, q);
      chk("swrst_rel_nd", q, 32'h1);

      // randomized register traffic
      for (int n = 0; n < 60; n++) begin
         d = $urandom;
         case ($urandom_range(0, 5))
            0: begin
               w = {4'($urandom_range(0, 3)), offs[$urandom_range(0, 4)]};
               wb_wr(w, d); m_wr(w, d);
            end
            1: begin
               wb_wr(8'hF3, d); m_wr(8'hF3, d);
            end
            2: begin
               wb_rd(8'hF3, q);
               chk("rnd_scr", q, m_scr);
            end
            3: begin
               case ($urandom_range(0, 2))
                  0: w = {4'($urandom_range(NCH, 11)), 4'($urandom)};
                  1: w = 8'($urandom_range(8'hC0, 8'hDF));
                  default: w = 8'($urandom_range(8'hF0, 8'hFF));
               endcase
               if (w == 8'hF3) w = 8'hF4;
               wb_rd(w, q);
               chk("rnd_zero", q, 0);
            end
            4: begin
               w = ($urandom_range(0, 1) == 0) ? 8'hF1 : 8'hF2;
               wb_wr(w, d); m_wr(w, d);
            end
            default: begin
               wb_wr(8'hE5, d); m_wr(8'hE5, d);
               wb_rd(8'hE5, q);
`ifdef GPS_CORR_IRQ_MASK_EN
               exp_mask = m_mask;
`else
               exp_mask = 0;
`endif
               chk("rnd_mask", q, exp_mask);
            end
         endcase
      end
      cmp_model("rnd");

      // reset in the middle of a read
      wb_wr(8'hF3, 32'hDEAD_BEEF);
      wb_rd(8'hEF, q);
      @(negedge clk);
      bus.wb_adr_i = {22'd0, 8'hE0, 2'b00};
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ack", bus.wb_ack_o, 0);
      chk("mid_rst_dat", bus.wb_dat_o, 0);
      chk("mid_rst_irq", accum_int, 0);
      acks = 0;
      bus.wb_adr_i = {22'd0, 8'hF3, 2'b00};
      bus.wb_dat_i = 32'h5555_5555;
      bus.wb_we_i  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.wb_ack_o) acks++;
      end
      chk("mid_rst_noack", acks, 0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wb_rd(8'hF3, q);
      chk("mid_rst_scr", q, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gps_multi_correlator.md
GPS_MULTI_CORRELATOR -- requirements
Module: gps_multi_correlator

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of tracking channels instantiated (legal 1..12).
REQ-002 SHALL have port correlator_clk  input  1  the single clock for all logic.
REQ-003 SHALL have port correlator_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports sign, mag  input  1 each  IF sample sign/magnitude, broadcast to all channels.
REQ-005 SHALL have port accum_int  output  1  accumulation interrupt, cleared by status clear.
REQ-006 SHALL have ports wb_adr_i, wb_dat_i  input  32 each; wb_dat_o  output  32; wb_sel_i  input  4 (ignored); wb_cyc_i, wb_stb_i, wb_we_i  input  1; wb_ack_o  output  1.

Function
REQ-007 SHALL instantiate one time_base and NUM_CH tracking_channel instances; all share internal rstn = ~correlator_rst & ~sw_rst.
REQ-008 SHALL decode word address w = wb_adr_i[9:2]; channel c = w[7:4] for w < 0xC0, offset o = w[3:0].
REQ-009 Channel offsets SHALL be: 0 prn_key[9:0] W; 1 carr_nco[28:0] W; 2 code_nco[27:0] W; 3 code_slew[10:0] W; 4..9 I/Q early, prompt, late R (16 bits, zero-extended); A carrier_val[31:0] R; B code_val[20:0] R; C epoch R; D epoch_check R; E epoch_load[10:0] W; F enables W.
REQ-010 Offset F write bits {2,1,0} = {epoch_enable, slew_enable, prn_key_enable}, each a one-cycle pulse to channel c only.
REQ-011 Access to c >= NUM_CH SHALL ignore writes and read 0.
REQ-012 Global map: E0 status R; E1 new_data R; E2 tic_count R; E3 accum_count R; E4 W bit0 = status clear, bit1 = new_data clear (one-cycle pulses); EF R constant 0x6E6D7275; F0 sw_rst W bit0 (level); F1 prog_tic[23:0] W; F2 prog_accum_int[23:0] W; F3 scratch[31:0] RW; all others read 0.
REQ-013 status[0] SHALL set on tic_enable, status[1] and accum_int on accum_enable; when a set and a clear occur in the same cycle, set SHALL win.
REQ-014 new_data[c] SHALL set on dump of channel c; a new_data clear SHALL clear all bits except channels dumping in that same cycle; bits >= NUM_CH read 0.
REQ-015 Bus FSM states IDLE, DELAYACK1, DELAYACK2, ACK; IDLE with cyc&stb: write -> ACK (register updated at that edge), read -> DELAYACK1 -> DELAYACK2 -> ACK; ACK -> IDLE unconditionally.
REQ-016 wb_ack_o SHALL be high exactly one cycle, only in ACK; write ack at request cycle +1, read ack at +3; wb_dat_o registered from current address, valid during ACK.
REQ-017 sw_rst = 1 SHALL hold time base, channels, status, new_data and accum_int in reset; bus registers (NCOs, prog_tic, scratch) SHALL retain values.

Reset
REQ-018 correlator_rst SHALL asynchronously clear all registers to 0, FSM to IDLE, wb_ack_o, wb_dat_o, accum_int, sw_rst to 0.
REQ-019 Reset mid-transaction SHALL abort it with no ack and no register update.

Configuration
REQ-020 With GPS_CORR_IRQ_MASK_EN defined: word E5 SHALL be irq_mask[1:0] RW, reset 2'b10, and accum_int = |(status & irq_mask).
REQ-021 Without GPS_CORR_IRQ_MASK_EN: E5 SHALL read 0, writes ignored, accum_int set/cleared per REQ-013.

Verification
REQ-022 Write 0x1234567 to ch1 offset 1 (w=0x11) -> ack 1 cycle after request, ch1 carr_nco = 0x1234567, ch0 unchanged.
REQ-023 Read w=0xEF -> ack 3 cycles after request, wb_dat_o = 0x6E6D7275.
REQ-024 NUM_CH=2, write/read w=0x31 -> no state change, read data 0.
REQ-025 Force accum_enable in same cycle as E4 write 0x1 -> status[1] = 1, accum_int = 1 after clear.
REQ-026 ch0 dump coincident with E4 write 0x2 while new_data = 0x3 -> new_data = 0x1.
REQ-027 Assert correlator_rst in DELAYACK2 -> no ack, all outputs 0 immediately.
